// File: rtl/riscv_superscalar_pkg.sv
// Shared types and constants for the dual-issue decode/execute slice.
// Provides the per-lane instruction bundle carried through the ID/EX register,
// the issue-state encoding used by the split FSM, and the datapath widths.
package riscv_superscalar_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int OP_W       = 5;
  localparam int CTRL_W     = 8;
  localparam int LANES      = 2;

  // PASS: bundles flow straight through.
  // HOLD: lane1 of a split bundle waits in the hold entry.
  typedef enum logic {
    PASS = 1'b0,
    HOLD = 1'b1
  } issue_state_e;

  // Everything execute needs for one instruction, moved as a single unit so
  // that a held instruction keeps exactly what decode produced for it.
  typedef struct packed {
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       imm;
    logic [XLEN-1:0]       rs1_data;
    logic [XLEN-1:0]       rs2_data;
    logic [REG_ADDR_W-1:0] rs1_addr;
    logic [REG_ADDR_W-1:0] rs2_addr;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic                  rs1_used;
    logic                  rs2_used;
    logic                  rd_we;
    logic [OP_W-1:0]       op_code;
    logic [CTRL_W-1:0]     ctrl;
  } lane_bundle_t;

endpackage

// File: rtl/intra_bundle_dep_check.sv
// Combinational read-after-write detector inside one decode bundle.
// Ports:
//   valid        lane valids of the incoming bundle (lane0 = older)
//   lane0_rd_*   destination of the older instruction
//   lane1_rs*    sources of the younger instruction and whether they are read
//   dep          1 when lane1 must not issue in the same cycle as lane0
module intra_bundle_dep_check
  import riscv_superscalar_pkg::*;
(
  input  logic [LANES-1:0]      valid,
  input  logic [REG_ADDR_W-1:0] lane0_rd_addr,
  input  logic                  lane0_rd_we,
  input  logic [REG_ADDR_W-1:0] lane1_rs1_addr,
  input  logic                  lane1_rs1_used,
  input  logic [REG_ADDR_W-1:0] lane1_rs2_addr,
  input  logic                  lane1_rs2_used,
  output logic                  dep
);

  logic rs1_hit;
  logic rs2_hit;

  // x0 is hardwired to zero, so a write to it never feeds lane1.
  always_comb begin
    rs1_hit = lane1_rs1_used && (lane1_rs1_addr == lane0_rd_addr);
    rs2_hit = lane1_rs2_used && (lane1_rs2_addr == lane0_rd_addr);
    dep     = (valid == 2'b11) && lane0_rd_we && (lane0_rd_addr != '0) &&
              (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/id_ex_dual_issue_reg.sv
// Dual-lane decode->execute pipeline register with bundle splitting.
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   flush               kills the registered bundle and any held instruction
//   dec_valid/dec_ready decode-side handshake (lane0 = older instruction)
//   dec_*               per-lane decoded payload
//   ex_valid/ex_ready   execute-side handshake, registered slot valids
//   ex_*                per-lane registered payload, zero for invalid slots
// When lane1 reads the register lane0 writes, lane0 issues alone and lane1 is
// parked in a hold entry, issuing next cycle from slot 0.
module id_ex_dual_issue_reg
  import riscv_superscalar_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush,
  input  logic [LANES-1:0]                  dec_valid,
  output logic                              dec_ready,
  input  logic [LANES-1:0][XLEN-1:0]        dec_pc,
  input  logic [LANES-1:0][XLEN-1:0]        dec_imm,
  input  logic [LANES-1:0][XLEN-1:0]        dec_rs1_data,
  input  logic [LANES-1:0][XLEN-1:0]        dec_rs2_data,
  input  logic [LANES-1:0][REG_ADDR_W-1:0]  dec_rs1_addr,
  input  logic [LANES-1:0][REG_ADDR_W-1:0]  dec_rs2_addr,
  input  logic [LANES-1:0][REG_ADDR_W-1:0]  dec_rd_addr,
  input  logic [LANES-1:0]                  dec_rs1_used,
  input  logic [LANES-1:0]                  dec_rs2_used,
  input  logic [LANES-1:0]                  dec_rd_we,
  input  logic [LANES-1:0][OP_W-1:0]        dec_op_code,
  input  logic [LANES-1:0][CTRL_W-1:0]      dec_ctrl,
  output logic [LANES-1:0]                  ex_valid,
  input  logic                              ex_ready,
  output logic [LANES-1:0][XLEN-1:0]        ex_pc,
  output logic [LANES-1:0][XLEN-1:0]        ex_imm,
  output logic [LANES-1:0][XLEN-1:0]        ex_rs1_data,
  output logic [LANES-1:0][XLEN-1:0]        ex_rs2_data,
  output logic [LANES-1:0][REG_ADDR_W-1:0]  ex_rs1_addr,
  output logic [LANES-1:0][REG_ADDR_W-1:0]  ex_rs2_addr,
  output logic [LANES-1:0][REG_ADDR_W-1:0]  ex_rd_addr,
  output logic [LANES-1:0]                  ex_rs1_used,
  output logic [LANES-1:0]                  ex_rs2_used,
  output logic [LANES-1:0]                  ex_rd_we,
  output logic [LANES-1:0][OP_W-1:0]        ex_op_code,
  output logic [LANES-1:0][CTRL_W-1:0]      ex_ctrl
);

  issue_state_e                 state_q, state_d;
  logic [LANES-1:0]             ex_valid_q, ex_valid_d;
  lane_bundle_t [LANES-1:0]     slot_q, slot_d;
  lane_bundle_t                 hold_q, hold_d;
  lane_bundle_t [LANES-1:0]     lane_in;
  logic                         adv;
  logic                         accept;
  logic                         dep;

  // Gather the flat decode ports into per-lane bundles.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_in[i].pc       = dec_pc[i];
      lane_in[i].imm      = dec_imm[i];
      lane_in[i].rs1_data = dec_rs1_data[i];
      lane_in[i].rs2_data = dec_rs2_data[i];
      lane_in[i].rs1_addr = dec_rs1_addr[i];
      lane_in[i].rs2_addr = dec_rs2_addr[i];
      lane_in[i].rd_addr  = dec_rd_addr[i];
      lane_in[i].rs1_used = dec_rs1_used[i];
      lane_in[i].rs2_used = dec_rs2_used[i];
      lane_in[i].rd_we    = dec_rd_we[i];
      lane_in[i].op_code  = dec_op_code[i];
      lane_in[i].ctrl     = dec_ctrl[i];
    end
  end

  intra_bundle_dep_check u_dep_check (
    .valid          (dec_valid),
    .lane0_rd_addr  (dec_rd_addr[0]),
    .lane0_rd_we    (dec_rd_we[0]),
    .lane1_rs1_addr (dec_rs1_addr[1]),
    .lane1_rs1_used (dec_rs1_used[1]),
    .lane1_rs2_addr (dec_rs2_addr[1]),
    .lane1_rs2_used (dec_rs2_used[1]),
    .dep            (dep)
  );

  // The output register may load when it is empty or execute is taking it.
  assign adv    = (ex_valid_q == '0) || ex_ready;
  assign accept = (dec_valid != '0) && dec_ready;

  // Output process: decode is only accepted in PASS, never during reset or
  // during a flush cycle.
  always_comb begin
    dec_ready = rst_n && !flush && (state_q == PASS) && adv;
  end

  // Next-state process.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = PASS;
    end else begin
      case (state_q)
        PASS: if (accept && dep) state_d = HOLD;
        HOLD: if (adv) state_d = PASS;
      endcase
    end
  end

  // Datapath: slots are zeroed whenever they are not valid so execute never
  // sees stale payload behind a cleared valid bit.
  always_comb begin
    ex_valid_d = ex_valid_q;
    slot_d     = slot_q;
    hold_d     = hold_q;
    if (flush) begin
      ex_valid_d = '0;
      slot_d     = '0;
      hold_d     = '0;
    end else if (state_q == HOLD) begin
      if (adv) begin
        slot_d[0]  = hold_q;
        slot_d[1]  = '0;
        ex_valid_d = 2'b01;
        hold_d     = '0;
      end
    end else if (adv) begin
      if (accept && dep) begin
        slot_d[0]  = lane_in[0];
        slot_d[1]  = '0;
        ex_valid_d = 2'b01;
        hold_d     = lane_in[1];
      end else if (accept) begin
        for (int i = 0; i < LANES; i++) begin
          slot_d[i] = dec_valid[i] ? lane_in[i] : '0;
        end
        ex_valid_d = dec_valid;
      end else begin
        ex_valid_d = '0;
        slot_d     = '0;
      end
    end
  end

  // State register, output slots and hold entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PASS;
      ex_valid_q <= '0;
      slot_q     <= '0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      ex_valid_q <= ex_valid_d;
      slot_q     <= slot_d;
      hold_q     <= hold_d;
    end
  end

  // Spread the registered slots back onto the flat execute ports.
  always_comb begin
    ex_valid = ex_valid_q;
    for (int i = 0; i < LANES; i++) begin
      ex_pc[i]       = slot_q[i].pc;
      ex_imm[i]      = slot_q[i].imm;
      ex_rs1_data[i] = slot_q[i].rs1_data;
      ex_rs2_data[i] = slot_q[i].rs2_data;
      ex_rs1_addr[i] = slot_q[i].rs1_addr;
      ex_rs2_addr[i] = slot_q[i].rs2_addr;
      ex_rd_addr[i]  = slot_q[i].rd_addr;
      ex_rs1_used[i] = slot_q[i].rs1_used;
      ex_rs2_used[i] = slot_q[i].rs2_used;
      ex_rd_we[i]    = slot_q[i].rd_we;
      ex_op_code[i]  = slot_q[i].op_code;
      ex_ctrl[i]     = slot_q[i].ctrl;
    end
  end

endmodule

// File: tb/tb_id_ex_dual_issue_reg.sv
// Directed bench for the dual-issue ID/EX register: reset, independent pairs,
// RAW split, x0/unused-source cases, back-pressure and flush while holding.
module tb_id_ex_dual_issue_reg;
  import riscv_superscalar_pkg::*;

  logic                             clk;
  logic                             rst_n;
  logic                             flush;
  logic [LANES-1:0]                 dec_valid;
  logic                             dec_ready;
  logic [LANES-1:0][XLEN-1:0]       dec_pc, dec_imm, dec_rs1_data, dec_rs2_data;
  logic [LANES-1:0][REG_ADDR_W-1:0] dec_rs1_addr, dec_rs2_addr, dec_rd_addr;
  logic [LANES-1:0]                 dec_rs1_used, dec_rs2_used, dec_rd_we;
  logic [LANES-1:0][OP_W-1:0]       dec_op_code;
  logic [LANES-1:0][CTRL_W-1:0]     dec_ctrl;
  logic [LANES-1:0]                 ex_valid;
  logic                             ex_ready;
  logic [LANES-1:0][XLEN-1:0]       ex_pc, ex_imm, ex_rs1_data, ex_rs2_data;
  logic [LANES-1:0][REG_ADDR_W-1:0] ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
  logic [LANES-1:0]                 ex_rs1_used, ex_rs2_used, ex_rd_we;
  logic [LANES-1:0][OP_W-1:0]       ex_op_code;
  logic [LANES-1:0][CTRL_W-1:0]     ex_ctrl;

  int compared;
  int mismatched;

  id_ex_dual_issue_reg dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .dec_valid    (dec_valid),
    .dec_ready    (dec_ready),
    .dec_pc       (dec_pc),
    .dec_imm      (dec_imm),
    .dec_rs1_data (dec_rs1_data),
    .dec_rs2_data (dec_rs2_data),
    .dec_rs1_addr (dec_rs1_addr),
    .dec_rs2_addr (dec_rs2_addr),
    .dec_rd_addr  (dec_rd_addr),
    .dec_rs1_used (dec_rs1_used),
    .dec_rs2_used (dec_rs2_used),
    .dec_rd_we    (dec_rd_we),
    .dec_op_code  (dec_op_code),
    .dec_ctrl     (dec_ctrl),
    .ex_valid     (ex_valid),
    .ex_ready     (ex_ready),
    .ex_pc        (ex_pc),
    .ex_imm       (ex_imm),
    .ex_rs1_data  (ex_rs1_data),
    .ex_rs2_data  (ex_rs2_data),
    .ex_rs1_addr  (ex_rs1_addr),
    .ex_rs2_addr  (ex_rs2_addr),
    .ex_rd_addr   (ex_rd_addr),
    .ex_rs1_used  (ex_rs1_used),
    .ex_rs2_used  (ex_rs2_used),
    .ex_rd_we     (ex_rd_we),
    .ex_op_code   (ex_op_code),
    .ex_ctrl      (ex_ctrl)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Upstream compacts bundles, so lane1-only is never a legal input.
  always @(negedge clk) begin
    if (rst_n) begin
      assert (dec_valid !== 2'b10) else begin
        mismatched++;
        $error("[TB] FAIL illegal_dec_valid: observed 2'b10 required anything else");
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one decode lane; operand data is derived from the pc so every
  // instruction carries distinguishable data.
  task automatic applyStimulus(input int l, input logic [31:0] pc, input logic [31:0] imm,
                               input logic [4:0] rs1, input logic u1,
                               input logic [4:0] rs2, input logic u2,
                               input logic [4:0] rd, input logic we,
                               input logic [4:0] op, input logic [7:0] ctrl);
    dec_pc[l]       = pc;
    dec_imm[l]      = imm;
    dec_rs1_data[l] = pc ^ 32'hA5A5_0000;
    dec_rs2_data[l] = pc ^ 32'h0000_5A5A;
    dec_rs1_addr[l] = rs1;
    dec_rs1_used[l] = u1;
    dec_rs2_addr[l] = rs2;
    dec_rs2_used[l] = u2;
    dec_rd_addr[l]  = rd;
    dec_rd_we[l]    = we;
    dec_op_code[l]  = op;
    dec_ctrl[l]     = ctrl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    flush      = 1'b0;
    ex_ready   = 1'b1;
    dec_valid  = 2'b00;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    checkOutput("reset_ex_valid", 64'(ex_valid), 64'h0);
    checkOutput("reset_dec_ready", 64'(dec_ready), 64'h0);
    checkOutput("reset_ex_pc0", 64'(ex_pc[0]), 64'h0);
    rst_n = 1'b1;
    tick();

    // Independent pair: addi x5,x1,-2048 / addi x6,x7,16.
    applyStimulus(0, 32'h100, 32'hFFFF_F800, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'h04, 8'h11);
    applyStimulus(1, 32'h104, 32'h0000_0010, 5'd7, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 5'h04, 8'h22);
    dec_valid = 2'b11;
    #1;
    checkOutput("pair_dec_ready", 64'(dec_ready), 64'h1);
    tick();
    checkOutput("pair_ex_valid", 64'(ex_valid), 64'h3);
    checkOutput("pair_imm0", 64'(ex_imm[0]), 64'hFFFF_F800);
    checkOutput("pair_imm1", 64'(ex_imm[1]), 64'h10);
    checkOutput("pair_pc1", 64'(ex_pc[1]), 64'h104);
    checkOutput("pair_rd1", 64'(ex_rd_addr[1]), 64'd6);
    checkOutput("pair_rs1addr1", 64'(ex_rs1_addr[1]), 64'd7);
    checkOutput("pair_rs1data0", 64'(ex_rs1_data[0]), 64'hA5A5_0100);
    checkOutput("pair_ctrl1", 64'(ex_ctrl[1]), 64'h22);

    // Reset mid-stream acts immediately, without waiting for a clock.
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_ex_valid", 64'(ex_valid), 64'h0);
    checkOutput("midreset_pc1", 64'(ex_pc[1]), 64'h0);
    checkOutput("midreset_imm0", 64'(ex_imm[0]), 64'h0);
    checkOutput("midreset_dec_ready", 64'(dec_ready), 64'h0);
    dec_valid = 2'b00;
    tick();
    rst_n = 1'b1;
    tick();

    // Single-lane bundle: slot1 stays invalid and zero.
    applyStimulus(0, 32'h180, 32'h5, 5'd2, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 5'h04, 8'h33);
    dec_valid = 2'b01;
    tick();
    checkOutput("single_ex_valid", 64'(ex_valid), 64'h1);
    checkOutput("single_pc0", 64'(ex_pc[0]), 64'h180);
    checkOutput("single_pc1", 64'(ex_pc[1]), 64'h0);

    // RAW split: lane1 reads x5 through rs2, which lane0 writes.
    applyStimulus(0, 32'h200, 32'h1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'h04, 8'h44);
    applyStimulus(1, 32'h204, 32'h0000_0ABC, 5'd9, 1'b1, 5'd5, 1'b1, 5'd8, 1'b1, 5'h0C, 8'h55);
    dec_valid = 2'b11;
    #1;
    checkOutput("split_dec_ready_in", 64'(dec_ready), 64'h1);
    tick();
    dec_valid = 2'b00;
    #1;
    checkOutput("split_c1_ex_valid", 64'(ex_valid), 64'h1);
    checkOutput("split_c1_pc0", 64'(ex_pc[0]), 64'h200);
    checkOutput("split_c1_pc1", 64'(ex_pc[1]), 64'h0);
    checkOutput("split_c1_dec_ready", 64'(dec_ready), 64'h0);
    tick();
    checkOutput("split_c2_ex_valid", 64'(ex_valid), 64'h1);
    checkOutput("split_c2_pc0", 64'(ex_pc[0]), 64'h204);
    checkOutput("split_c2_imm0", 64'(ex_imm[0]), 64'hABC);
    checkOutput("split_c2_rd0", 64'(ex_rd_addr[0]), 64'd8);
    checkOutput("split_c2_ctrl0", 64'(ex_ctrl[0]), 64'h55);
    checkOutput("split_c2_op0", 64'(ex_op_code[0]), 64'h0C);
    checkOutput("split_c2_pc1", 64'(ex_pc[1]), 64'h0);
    checkOutput("split_c3_dec_ready", 64'(dec_ready), 64'h1);
    tick();
    checkOutput("split_bubble_ex_valid", 64'(ex_valid), 64'h0);
    checkOutput("split_bubble_pc0", 64'(ex_pc[0]), 64'h0);

    // lane0 writes x0: no dependency even though lane1 reads x0.
    applyStimulus(0, 32'h300, 32'h0, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 5'h04, 8'h00);
    applyStimulus(1, 32'h304, 32'h0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd4, 1'b1, 5'h0C, 8'h00);
    dec_valid = 2'b11;
    tick();
    checkOutput("x0_ex_valid", 64'(ex_valid), 64'h3);
    checkOutput("x0_pc1", 64'(ex_pc[1]), 64'h304);

    // Address match on an unused rs1 is not a dependency.
    applyStimulus(0, 32'h310, 32'h0, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'h04, 8'h00);
    applyStimulus(1, 32'h314, 32'h0, 5'd5, 1'b0, 5'd9, 1'b1, 5'd4, 1'b1, 5'h0C, 8'h00);
    tick();
    checkOutput("unused_ex_valid", 64'(ex_valid), 64'h3);
    checkOutput("unused_pc1", 64'(ex_pc[1]), 64'h314);

    // Back-pressure: A registered, B waits three cycles, then loads once.
    applyStimulus(0, 32'h400, 32'h0, 5'd1, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 5'h04, 8'h00);
    applyStimulus(1, 32'h404, 32'h0, 5'd2, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 5'h04, 8'h00);
    tick();
    checkOutput("bp_a_ex_valid", 64'(ex_valid), 64'h3);
    ex_ready = 1'b0;
    applyStimulus(0, 32'h500, 32'h0, 5'd1, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 5'h04, 8'h00);
    applyStimulus(1, 32'h504, 32'h0, 5'd2, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 5'h04, 8'h00);
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput("bp_stall_dec_ready", 64'(dec_ready), 64'h0);
      tick();
      checkOutput("bp_stall_pc0", 64'(ex_pc[0]), 64'h400);
      checkOutput("bp_stall_pc1", 64'(ex_pc[1]), 64'h404);
    end
    ex_ready = 1'b1;
    #1;
    checkOutput("bp_release_dec_ready", 64'(dec_ready), 64'h1);
    tick();
    dec_valid = 2'b00;
    checkOutput("bp_b_ex_valid", 64'(ex_valid), 64'h3);
    checkOutput("bp_b_pc0", 64'(ex_pc[0]), 64'h500);
    checkOutput("bp_b_pc1", 64'(ex_pc[1]), 64'h504);
    tick();
    checkOutput("bp_nodup_ex_valid", 64'(ex_valid), 64'h0);

    // Flush while lane1 is held: held instruction must never appear.
    applyStimulus(0, 32'h600, 32'h0, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'h04, 8'h00);
    applyStimulus(1, 32'h604, 32'h0, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 5'h04, 8'h00);
    dec_valid = 2'b11;
    tick();
    dec_valid = 2'b00;
    flush     = 1'b1;
    #1;
    checkOutput("flush_hold_ex_valid", 64'(ex_valid), 64'h1);
    checkOutput("flush_dec_ready", 64'(dec_ready), 64'h0);
    tick();
    flush = 1'b0;
    checkOutput("flush_ex_valid", 64'(ex_valid), 64'h0);
    checkOutput("flush_pc0", 64'(ex_pc[0]), 64'h0);
    applyStimulus(0, 32'h700, 32'h0, 5'd1, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 5'h04, 8'h00);
    applyStimulus(1, 32'h704, 32'h0, 5'd2, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 5'h04, 8'h00);
    dec_valid = 2'b11;
    #1;
    checkOutput("postflush_dec_ready", 64'(dec_ready), 64'h1);
    tick();
    dec_valid = 2'b00;
    checkOutput("postflush_ex_valid", 64'(ex_valid), 64'h3);
    checkOutput("postflush_pc0", 64'(ex_pc[0]), 64'h700);
    checkOutput("postflush_pc1", 64'(ex_pc[1]), 64'h704);
    tick();
    checkOutput("postflush_idle_ex_valid", 64'(ex_valid), 64'h0);
    checkOutput("postflush_idle_pc0", 64'(ex_pc[0]), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
